// File: rtl/or1300_exe_defines_pkg.sv
// Shared execute-stage definitions: unit select codes and result-buffer occupancy states.
package or1300_exe_defines;

  localparam logic [2:0] EXE_ADD     = 3'd0;
  localparam logic [2:0] EXE_LOGIC   = 3'd1;
  localparam logic [2:0] EXE_SHIFT   = 3'd2;
  localparam logic [2:0] EXE_BITFIND = 3'd3;
  localparam logic [2:0] EXE_COMPARE = 3'd4;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } bufStateT;

endpackage

// File: rtl/exe_result_buffer_entry.sv
// Load-enabled {dest, we, data} result entry; used as head and skid of the result buffer.
module result_entry_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [REG_W-1:0]  loadDest,
  input  logic              loadWe,
  input  logic [DATA_W-1:0] loadData,
  output logic [REG_W-1:0]  dest,
  output logic              we,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dest <= '0;
      we   <= 1'b0;
      data <= '0;
    end else if (load) begin
      dest <= loadDest;
      we   <= loadWe;
      data <= loadData;
    end
  end

endmodule

// File: rtl/exe_result_buffer.sv
// Execute-stage result collector: unit select, two-entry elastic writeback buffer,
// forwarding tap and the architectural compare flag SR[F].
module exe_result_buffer
  import or1300_exe_defines::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              exeValid,
  output logic              exeReady,
  input  logic [2:0]        exeUnit,
  input  logic [REG_W-1:0]  exeDest,
  input  logic              exeWe,
  input  logic [DATA_W-1:0] adderResult,
  input  logic [DATA_W-1:0] logicResult,
  input  logic [DATA_W-1:0] shiftResult,
  input  logic [DATA_W-1:0] bitFinderResult,
  input  logic              compareResult,
  output logic              wbValid,
  input  logic              wbReady,
  output logic [REG_W-1:0]  wbDest,
  output logic              wbWe,
  output logic [DATA_W-1:0] wbData,
  output logic              fwdValid,
  output logic [REG_W-1:0]  fwdDest,
  output logic [DATA_W-1:0] fwdData,
  output logic              flag
);

  bufStateT          state, stateNext;
  logic              accept, pop;
  logic [DATA_W-1:0] newData;
  logic              newWe;
  logic              headLoad, skidLoad, headFromSkid;
  logic [REG_W-1:0]  headDinDest, skidDest;
  logic              headDinWe, skidWe;
  logic [DATA_W-1:0] headDinData, skidData;
  logic              useSkid;

  assign accept = exeValid & exeReady & ~flush;
  // A flushed cycle never counts as a writeback handshake.
  assign pop    = wbValid & wbReady & ~flush;

  // Compare and reserved units occupy a slot only to keep retire order.
  always_comb begin
    newData = '0;
    newWe   = 1'b0;
    case (exeUnit)
      EXE_ADD:     begin newData = adderResult;     newWe = exeWe; end
      EXE_LOGIC:   begin newData = logicResult;     newWe = exeWe; end
      EXE_SHIFT:   begin newData = shiftResult;     newWe = exeWe; end
      EXE_BITFIND: begin newData = bitFinderResult; newWe = exeWe; end
      default:     ;
    endcase
  end

  always_comb begin
    stateNext    = state;
    headLoad     = 1'b0;
    skidLoad     = 1'b0;
    headFromSkid = 1'b0;
    if (flush) begin
      stateNext = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: if (accept) begin
          headLoad  = 1'b1;
          stateNext = BUF_ONE;
        end
        BUF_ONE: begin
          if (accept && pop) begin
            headLoad = 1'b1;
          end else if (accept) begin
            skidLoad  = 1'b1;
            stateNext = BUF_TWO;
          end else if (pop) begin
            stateNext = BUF_EMPTY;
          end
        end
        BUF_TWO: if (pop) begin
          headLoad     = 1'b1;
          headFromSkid = 1'b1;
          stateNext    = BUF_ONE;
        end
        default: stateNext = BUF_EMPTY;
      endcase
    end
  end

  // exeReady is registered from the next state so wbReady never reaches it combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= BUF_EMPTY;
      exeReady <= 1'b1;
      flag     <= 1'b0;
    end else begin
      state    <= stateNext;
      exeReady <= (stateNext != BUF_TWO);
      if (accept && exeUnit == EXE_COMPARE) flag <= compareResult;
    end
  end

  assign headDinDest = headFromSkid ? skidDest : exeDest;
  assign headDinWe   = headFromSkid ? skidWe   : newWe;
  assign headDinData = headFromSkid ? skidData : newData;

  result_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) headEntry (
    .clock    (clock),
    .reset    (reset),
    .load     (headLoad),
    .loadDest (headDinDest),
    .loadWe   (headDinWe),
    .loadData (headDinData),
    .dest     (wbDest),
    .we       (wbWe),
    .data     (wbData)
  );

  result_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) skidEntry (
    .clock    (clock),
    .reset    (reset),
    .load     (skidLoad),
    .loadDest (exeDest),
    .loadWe   (newWe),
    .loadData (newData),
    .dest     (skidDest),
    .we       (skidWe),
    .data     (skidData)
  );

  assign wbValid = (state != BUF_EMPTY);

  // Youngest writing entry wins the forwarding tap.
  assign useSkid  = (state == BUF_TWO) && skidWe;
  assign fwdDest  = useSkid ? skidDest : wbDest;
  assign fwdData  = useSkid ? skidData : wbData;
  assign fwdValid = (state != BUF_EMPTY) && (useSkid ? skidWe : wbWe);

endmodule

// File: tb/tb_exe_result_buffer.sv
// Bench for exe_result_buffer: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_exe_result_buffer;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              exeValid;
  logic              exeReady;
  logic [2:0]        exeUnit;
  logic [REG_W-1:0]  exeDest;
  logic              exeWe;
  logic [DATA_W-1:0] adderResult, logicResult, shiftResult, bitFinderResult;
  logic              compareResult;
  logic              wbValid;
  logic              wbReady;
  logic [REG_W-1:0]  wbDest;
  logic              wbWe;
  logic [DATA_W-1:0] wbData;
  logic              fwdValid;
  logic [REG_W-1:0]  fwdDest;
  logic [DATA_W-1:0] fwdData;
  logic              flag;

  int checks   = 0;
  int failures = 0;

  exe_result_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .exeValid        (exeValid),
    .exeReady        (exeReady),
    .exeUnit         (exeUnit),
    .exeDest         (exeDest),
    .exeWe           (exeWe),
    .adderResult     (adderResult),
    .logicResult     (logicResult),
    .shiftResult     (shiftResult),
    .bitFinderResult (bitFinderResult),
    .compareResult   (compareResult),
    .wbValid         (wbValid),
    .wbReady         (wbReady),
    .wbDest          (wbDest),
    .wbWe            (wbWe),
    .wbData          (wbData),
    .fwdValid        (fwdValid),
    .fwdDest         (fwdDest),
    .fwdData         (fwdData),
    .flag            (flag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic              we;
    logic [DATA_W-1:0] data;
  } entT;

  entT  mq[$];
  logic mFlag;

  typedef struct {
    bit          v;
    logic [2:0]  unit;
    logic [4:0]  dest;
    bit          we;
    logic [31:0] val;
    bit          cmp;
    bit          rdy;
    bit          fl;
    bit          xWbValid;
    logic [31:0] xData;
    bit          xReady;
    bit          xFlag;
    bit          xFwd;
  } vecT;

  vecT tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model entry derived from the unit-select rule: units 0-3 carry their bus, others store 0 / no write.
  function automatic entT modelEntry();
    entT e;
    e.dest = exeDest;
    e.we   = (exeUnit <= 3'd3) ? exeWe : 1'b0;
    case (exeUnit)
      3'd0: e.data = adderResult;
      3'd1: e.data = logicResult;
      3'd2: e.data = shiftResult;
      3'd3: e.data = bitFinderResult;
      default: e.data = '0;
    endcase
    return e;
  endfunction

  task automatic checkModel();
    int k;
    chk("wbValid", 64'(wbValid), 64'(mq.size() > 0));
    chk("exeReady", 64'(exeReady), 64'(mq.size() < 2));
    chk("flag", 64'(flag), 64'(mFlag));
    if (mq.size() > 0) begin
      chk("wbDest", 64'(wbDest), 64'(mq[0].dest));
      chk("wbWe", 64'(wbWe), 64'(mq[0].we));
      chk("wbData", 64'(wbData), 64'(mq[0].data));
    end
    k = -1;
    for (int i = 0; i < mq.size(); i++) if (mq[i].we) k = i;
    chk("fwdValid", 64'(fwdValid), 64'(k >= 0));
    if (k >= 0) begin
      chk("fwdDest", 64'(fwdDest), 64'(mq[k].dest));
      chk("fwdData", 64'(fwdData), 64'(mq[k].data));
    end
  endtask

  task automatic tick();
    entT e;
    bit  acc, pp;
    acc = exeValid && (mq.size() < 2) && !flush;
    pp  = (mq.size() > 0) && wbReady && !flush;
    e   = modelEntry();
    @(posedge clock);
    if (flush) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (exeUnit == 3'd4) mFlag = compareResult;
      end
    end
    #1;
    checkModel();
  endtask

  // Unselected buses carry the complement so a wrong select is visible.
  task automatic drive(input bit v, input logic [2:0] unit, input logic [4:0] dest, input bit we,
                       input logic [31:0] val, input bit cmp, input bit rdy, input bit fl);
    exeValid        = v;
    exeUnit         = unit;
    exeDest         = dest;
    exeWe           = we;
    adderResult     = (unit == 3'd0) ? val : ~val;
    logicResult     = (unit == 3'd1) ? val : ~val;
    shiftResult     = (unit == 3'd2) ? val : ~val;
    bitFinderResult = (unit == 3'd3) ? val : ~val;
    compareResult   = cmp;
    wbReady         = rdy;
    flush           = fl;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(0, 3'd0, 5'd0, 0, 32'd0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    mq.delete();
    mFlag = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 3'd3, 5'd7, 1, 32'h1F, 0, 1, 0, 1, 32'h1F, 1, 0, 1};
    tbl[1]  = '{1, 3'd4, 5'd3, 1, 32'h0,  1, 1, 0, 1, 32'h0,  1, 1, 0};
    tbl[2]  = '{1, 3'd3, 5'd9, 1, 32'h5,  0, 1, 0, 1, 32'h5,  1, 1, 1};
    tbl[3]  = '{0, 3'd0, 5'd0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 1, 0};
    tbl[4]  = '{1, 3'd0, 5'd1, 1, 32'd1,  0, 0, 0, 1, 32'd1,  1, 1, 1};
    tbl[5]  = '{1, 3'd0, 5'd2, 1, 32'd2,  0, 0, 0, 1, 32'd1,  0, 1, 1};
    tbl[6]  = '{1, 3'd0, 5'd3, 1, 32'd3,  0, 0, 0, 1, 32'd1,  0, 1, 1};
    tbl[7]  = '{1, 3'd0, 5'd3, 1, 32'd3,  0, 1, 0, 1, 32'd2,  1, 1, 1};
    tbl[8]  = '{1, 3'd0, 5'd3, 1, 32'd3,  0, 1, 0, 1, 32'd3,  1, 1, 1};
    tbl[9]  = '{0, 3'd0, 5'd0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 1, 0};
    tbl[10] = '{1, 3'd0, 5'd4, 1, 32'd10, 0, 0, 0, 1, 32'd10, 1, 1, 1};
    tbl[11] = '{1, 3'd0, 5'd5, 1, 32'd11, 0, 0, 0, 1, 32'd10, 0, 1, 1};
    tbl[12] = '{1, 3'd0, 5'd6, 1, 32'd12, 0, 1, 1, 0, 32'h0,  1, 1, 0};
    tbl[13] = '{1, 3'd0, 5'd6, 1, 32'd12, 0, 1, 0, 1, 32'd12, 1, 1, 1};
    tbl[14] = '{1, 3'd1, 5'd8, 1, 32'd13, 0, 1, 0, 1, 32'd13, 1, 1, 1};
    tbl[15] = '{1, 3'd5, 5'd9, 1, 32'd14, 0, 0, 0, 1, 32'd13, 0, 1, 1};
    tbl[16] = '{0, 3'd0, 5'd0, 0, 32'h0,  0, 1, 0, 1, 32'h0,  1, 1, 0};
    tbl[17] = '{0, 3'd0, 5'd0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 1, 0};
    tbl[18] = '{1, 3'd4, 5'd2, 1, 32'h0,  0, 1, 0, 1, 32'h0,  1, 0, 0};
    tbl[19] = '{0, 3'd0, 5'd0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  1, 0, 0};
    tbl[20] = '{1, 3'd4, 5'd0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  1, 0, 0};

    doReset();
    #1;
    chk("rst_wbValid", 64'(wbValid), 64'd0);
    chk("rst_wbWe", 64'(wbWe), 64'd0);
    chk("rst_wbDest", 64'(wbDest), 64'd0);
    chk("rst_wbData", 64'(wbData), 64'd0);
    chk("rst_fwdValid", 64'(fwdValid), 64'd0);
    chk("rst_fwdDest", 64'(fwdDest), 64'd0);
    chk("rst_fwdData", 64'(fwdData), 64'd0);
    chk("rst_exeReady", 64'(exeReady), 64'd1);
    chk("rst_flag", 64'(flag), 64'd0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].unit, tbl[i].dest, tbl[i].we, tbl[i].val,
            tbl[i].cmp, tbl[i].rdy, tbl[i].fl);
      tick();
      chk($sformatf("vec%0d_wbValid", i), 64'(wbValid), 64'(tbl[i].xWbValid));
      if (tbl[i].xWbValid) chk($sformatf("vec%0d_wbData", i), 64'(wbData), 64'(tbl[i].xData));
      chk($sformatf("vec%0d_exeReady", i), 64'(exeReady), 64'(tbl[i].xReady));
      chk($sformatf("vec%0d_flag", i), 64'(flag), 64'(tbl[i].xFlag));
      chk($sformatf("vec%0d_fwdValid", i), 64'(fwdValid), 64'(tbl[i].xFwd));
    end
    chk("bf_dest_vec0", 64'(tbl[0].dest), 64'd7);

    // Asynchronous reset between edges with two entries buffered and flag set.
    drive(1, 3'd4, 5'd1, 0, 32'h0, 1, 0, 0);
    tick();
    drive(1, 3'd0, 5'd2, 1, 32'hABCD, 0, 0, 0);
    tick();
    drive(0, 3'd0, 5'd0, 0, 32'h0, 0, 0, 0);
    chk("pre_rst_flag", 64'(flag), 64'd1);
    chk("pre_rst_full", 64'(exeReady), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_wbValid", 64'(wbValid), 64'd0);
    chk("async_rst_flag", 64'(flag), 64'd0);
    chk("async_rst_exeReady", 64'(exeReady), 64'd1);
    chk("async_rst_fwdValid", 64'(fwdValid), 64'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    mq.delete();
    mFlag = 1'b0;

    for (int n = 0; n < 600; n++) begin
      exeValid        = ($urandom % 4) != 0;
      exeUnit         = 3'($urandom % 8);
      exeDest         = 5'($urandom);
      exeWe           = 1'($urandom);
      adderResult     = $urandom;
      logicResult     = $urandom;
      shiftResult     = $urandom;
      bitFinderResult = $urandom;
      compareResult   = 1'($urandom);
      wbReady         = ($urandom % 3) != 0;
      flush           = ($urandom % 16) == 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_result_buffer.md
# exe_result_buffer

Execute-stage result collector for the or1300 pipeline, directly downstream of the bit finder and the other execute units. It selects the active unit's result, holds it for the writeback stage in a two-entry elastic buffer with a ready/valid handshake, and owns the architectural compare flag (SR[F]). The `flag` input of the bit finder, used for conditional move, is driven from this block's `flag` output.

## Interface
- `DATA_W`, default 32: result width.
- `REG_W`, default 5: destination register index width.

- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous pipeline flush (exception or branch mispredict).
- `exeValid` in 1: execute stage offers an instruction.
- `exeReady` out 1: block can accept an instruction. Registered.
- `exeUnit` in 3: 0 adder, 1 logic, 2 shifter, 3 bit finder, 4 compare, 5–7 reserved.
- `exeDest` in REG_W: destination register.
- `exeWe` in 1: instruction writes the register file.
- `adderResult`, `logicResult`, `shiftResult`, `bitFinderResult` in DATA_W each: execute unit results.
- `compareResult` in 1: compare outcome.
- `wbValid` out 1: writeback entry present.
- `wbReady` in 1: writeback accepts the entry.
- `wbDest` out REG_W: destination of the head entry.
- `wbWe` out 1: write enable of the head entry.
- `wbData` out DATA_W: data of the head entry.
- `fwdValid` out 1 / `fwdDest` out REG_W / `fwdData` out DATA_W: forwarding tap, youngest buffered entry with `wbWe`=1.
- `flag` out 1: SR[F], to the bit finder and branch unit.

## Operation
- Accept = `exeValid & exeReady & ~flush`. Pop = `wbValid & wbReady`.
- Data select by `exeUnit`: 0–3 take the matching result bus. Compare (4) and reserved codes (5–7) store data 0 with `we`=0.
- Entry fields: `{dest, we, data}`. Compare instructions still occupy an entry, which keeps retire order.
- FSM over buffer occupancy:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on pop without accept.
  - ONE stays ONE on pop with accept; the head is replaced.
  - ONE → TWO on accept without pop; the new entry goes to skid.
  - TWO → ONE on pop; skid moves to head. No accept is possible in TWO.
- `exeReady` = 1 in EMPTY and ONE, 0 in TWO. It is driven from the state register, with no combinational path from `wbReady`.
- Flag: on accept with `exeUnit`=4, `flag` ← `compareResult`. Otherwise it holds. Flush does not restore the flag, because a compare already accepted counts as committed.
- `flush`: state → EMPTY and all accepts in that cycle are suppressed. Entry data registers need not be cleared. A flush overrides a simultaneous pop; the pop is not seen as a handshake.
- Forwarding:
  - In TWO, the skid entry is used if its `we`=1, else the head entry.
  - In ONE, the head entry is used.
  - `fwdValid` = 1 only when the chosen entry has `we`=1.
  - In EMPTY, `fwdValid`=0.

## Timing
- Reset values:
  - state EMPTY, `exeReady`=1.
  - `wbValid`=0, `wbWe`=0, `wbDest`=0, `wbData`=0.
  - `fwdValid`=0, `fwdDest`=0, `fwdData`=0.
  - `flag`=0.
- Latency: an instruction accepted at edge N is on `wb*` after edge N; `wbValid`=1 in cycle N+1.
- Throughput: one instruction per cycle while `wbReady`=1.
- `flag` changes the cycle after the compare is accepted, so the next instruction sees the new value at the bit finder.
- `wb*` outputs are stable while `wbValid & ~wbReady`.
- Asynchronous `reset` mid-transfer discards both entries immediately.

## Structure
- Shared package/header `or1300_exe_defines`: unit codes (`EXE_ADD`=0, `EXE_LOGIC`=1, `EXE_SHIFT`=2, `EXE_BITFIND`=3, `EXE_COMPARE`=4) and state encodings.
- One sub-module: `result_entry_reg`, a load-enabled `{dest, we, data}` register with async reset. It is instantiated twice, as head and skid.
- Unit select and the FSM stay in the top level.

## Test plan
- Reset release, then `exeValid`=1, `exeUnit`=3, `bitFinderResult`=0x0000001F, `exeDest`=7, `exeWe`=1, with `wbReady`=1 → next cycle `wbValid`=1, `wbDest`=7, `wbData`=0x1F; `fwdValid`=1, `fwdDest`=7.
- Compare with `compareResult`=1, then cmov → `flag`=1 from the cycle after the compare accept; the compare entry reaches writeback with `wbWe`=0.
- `wbReady`=0, then three back-to-back adder results 1, 2, 3 →
  - 1 is accepted to head and 2 to skid;
  - `exeReady`=0 in the cycle after the second accept;
  - 3 is stalled;
  - after `wbReady`=1, order 1, 2, 3 arrives with no loss.
- State TWO with `flush`=1 and `wbReady`=1 → next cycle `wbValid`=0, `exeReady`=1, `flag` unchanged.
- Simultaneous accept and pop in ONE → occupancy stays ONE and `wbData` is the new value.
- Assert `reset` asynchronously mid-stream between edges → `wbValid` and `flag` drop to 0 before the next edge.
